spi_byte_receiver: RTL and testbench
====================================

SPI_BYTE_RECEIVER -- requirements
Module: spi_byte_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bits per SPI word and the rx_data/tx_data width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer flop depth on sclk, cs_n and mosi (minimum 2).
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port sclk, input, 1, SPI clock from the master, asynchronous to clk.
REQ-006 SHALL have port cs_n, input, 1, active-low chip select, asynchronous.
REQ-007 SHALL have port mosi, input, 1, serial data in, MSB first.
REQ-008 SHALL have port miso, output, 1, serial data out, MSB first (see REQ-024).
REQ-009 SHALL have port tx_data, input, WIDTH, word to transmit, captured at word start.
REQ-010 SHALL have port rx_data, output, WIDTH, last complete received word; held stable between rx_valid pulses.
REQ-011 SHALL have port rx_valid, output, 1, single-cycle pulse when rx_data updates; drives the enable of the downstream register.
REQ-012 SHALL have port busy, output, 1, high while in state SHIFT.

Function
REQ-013 SHALL implement SPI mode 0: mosi sampled on the synchronized sclk rising edge, miso changed on the synchronized sclk falling edge.
REQ-014 SHALL detect edges by comparing the last two synchronizer outputs; one edge per clk cycle at most (requires f_clk >= 4 x f_sclk).
REQ-015 SHALL have FSM states IDLE and SHIFT; IDLE->SHIFT on synchronized cs_n falling; any state->IDLE on synchronized cs_n high.
REQ-016 SHALL, on the IDLE->SHIFT transition, clear the bit counter and load tx_data into the transmit shift register.
REQ-017 SHALL, in SHIFT on each sclk rising edge, shift mosi into the LSB of the receive shift register and increment the bit counter (width clog2(WIDTH)).
REQ-018 SHALL, on the sclk rising edge that completes bit WIDTH-1, copy the assembled word to rx_data and pulse rx_valid high in the next clk cycle only.
REQ-019 SHALL, on word completion with cs_n still low, wrap the bit counter to 0, reload tx_data, and continue receiving back-to-back words.
REQ-020 SHALL, when cs_n rises mid-word, discard the partial word: no rx_valid, rx_data unchanged, counter cleared.
REQ-021 SHALL ignore sclk edges while in IDLE.
REQ-022 SHALL, if the cs_n rising edge and the completing sclk edge are detected in the same cycle, complete the word (rx_valid pulses) and then enter IDLE.

Reset
REQ-023 SHALL, while rst is high, asynchronously force: state IDLE, synchronizers to idle levels (sclk 0, cs_n 1, mosi 0), shift registers and counter 0, rx_data 0, rx_valid 0, busy 0, miso 0.

Configuration
REQ-024 SHALL, with macro SPI_BYTE_RECEIVER_TX_EN defined, include the tx_data port and transmit shift register, with miso presenting its MSB and shifting left on each sclk falling edge in SHIFT.
REQ-025 SHALL, without SPI_BYTE_RECEIVER_TX_EN, omit the tx_data port and transmit logic and tie miso to 0.

Structure
REQ-026 SHALL place the FSM state encodings (IDLE=1'b0, SHIFT=1'b1) and the default SYNC_STAGES constant in shared package spi_pkg.
REQ-027 SHALL instantiate sub-module sync_ff (parameter STAGES, asynchronous-reset init value) three times, for sclk, cs_n and mosi.

Verification
REQ-028 SHALL verify single word: cs_n low, shift 0xA5 at clk/8 -> one rx_valid pulse, rx_data=0xA5, busy falls after cs_n high.
REQ-029 SHALL verify back-to-back words: shift 0x3C then 0xC3 under one cs_n low -> two rx_valid pulses with rx_data 0x3C then 0xC3.
REQ-030 SHALL verify abort: cs_n rises after 5 bits of 0xFF, previous rx_data=0x12 -> no rx_valid, rx_data stays 0x12.
REQ-031 SHALL verify transmit (TX_EN): tx_data=0x81 while receiving 0x00 -> miso bit sequence 1,0,0,0,0,0,0,1; without TX_EN -> miso constantly 0.
REQ-032 SHALL verify reset mid-word: assert rst after 3 bits -> outputs 0 immediately, without waiting for clk; next full word 0x5A is received correctly.
REQ-033 SHALL verify downstream stage: rx_valid/rx_data drive generic_register enable/data_in -> its data_out equals 0xA5 one cycle after the rx_valid pulse.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte receiver: FSM state encoding,
// default synchronizer depth and a counter-width helper.
`timescale 1ns/1ps
package spi_pkg;

  // Receiver FSM states: IDLE waits for chip select, SHIFT moves bits.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Two flops are the minimum for a usable metastability window.
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Bit-counter width for a word of w bits; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/generic_register.sv
// Enable-loaded register used as the stage downstream of the receiver.
`timescale 1ns/1ps
module generic_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // Load data_in whenever enable is high, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (enable) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
// INIT is the level the chain takes during reset, so an idle line does not
// produce a spurious edge when reset is released.
`timescale 1ns/1ps
module sync_ff #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Depths below two are promoted to two.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {N{INIT}};
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 slave receiver running entirely in the clk domain.
// sclk, cs_n and mosi are synchronized, edges are found by comparing the
// synchronizer output with its previous value, and a two-state FSM
// assembles MSB-first words of WIDTH bits.
//
// Optional transmit path: define SPI_BYTE_RECEIVER_TX_EN to add the tx_data
// port and a transmit shift register driving miso; otherwise miso is 0.
//
// state | meaning
// IDLE  | chip select high, sclk ignored
// SHIFT | chip select low, bits shifted on synchronized sclk edges
`timescale 1ns/1ps
module spi_byte_receiver
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
`ifdef SPI_BYTE_RECEIVER_TX_EN
  input  logic [WIDTH-1:0] tx_data,
`endif
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  // The final bit comes straight from mosi, so only WIDTH-1 bits are held.
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_next;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic sclk_rise, cs_fall, word_done;

  sync_ff #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
    .clk (clk),
    .rst (rst),
    .d   (sclk),
    .q   (sclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d   (cs_n),
    .q   (cs_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d   (mosi),
    .q   (mosi_s)
  );

  // Keep the previous synchronized levels for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  // mosi_s has the same latency as sclk_s, so it is aligned with the edge.
  assign rx_next   = {rx_shift, mosi_s};
  assign word_done = (state == SHIFT) && sclk_rise && (bit_cnt == LAST_BIT);

  // Receive FSM: word assembly, completion pulse and chip-select handling.
  // A completing edge seen together with cs_n high still delivers the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= SHIFT;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              rx_shift <= '0;
            end else begin
              rx_shift <= rx_next[WIDTH-2:0];
              bit_cnt  <= bit_cnt + CNT_W'(1);
            end
          end
          if (cs_s) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_BYTE_RECEIVER_TX_EN
  logic [WIDTH-1:0] tx_shift;
  logic             sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_d;

  // Transmit shifter: load at word start, shift on falling edges. The
  // falling edge right after a reload (bit_cnt 0) must keep the new MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
    end else if (state == IDLE) begin
      tx_shift <= cs_fall ? tx_data : '0;
    end else if (cs_s) begin
      tx_shift <= '0;
    end else if (word_done) begin
      tx_shift <= tx_data;
    end else if (sclk_fall && (bit_cnt != '0)) begin
      tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
    end
  end

  assign miso = tx_shift[WIDTH-1];
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_receiver.sv
`timescale 1ns/1ps
module tb_spi_byte_receiver;

  localparam int W = 8;
`ifdef SPI_BYTE_RECEIVER_TX_EN
  localparam bit TX_EN = 1'b1;
`else
  localparam bit TX_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, sclk, cs_n, mosi, miso, rx_valid, busy;
  logic [W-1:0] rx_data, dn_q, tx_word, tx_cap;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  spi_byte_receiver #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
`ifdef SPI_BYTE_RECEIVER_TX_EN
    .tx_data  (tx_word),
`endif
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  generic_register #(.WIDTH(W)) u_dn (
    .clk      (clk),
    .rst      (rst),
    .enable   (rx_valid),
    .data_in  (rx_data),
    .data_out (dn_q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid pulse pops one expected word; the downstream
  // register must hold that word one cycle later.
  logic         prev_valid = 1'b0;
  logic         dn_pend    = 1'b0;
  logic [W-1:0] dn_exp     = '0;
  always @(negedge clk) begin
    if (dn_pend) begin
      chk("downstream_data_out", dn_q, dn_exp);
      dn_pend = 1'b0;
    end
    if (rx_valid === 1'b1) begin
      chk("rx_valid_single_cycle", prev_valid, 1'b0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rx_valid: got pulse with rx_data %0h expected no pulse", rx_data);
      end else begin
        dn_exp = exp_q.pop_front();
        chk("rx_data", rx_data, dn_exp);
        dn_pend = 1'b1;
      end
    end
    prev_valid = (rx_valid === 1'b1);
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_start();
    tx_cap = tx_word;
    cs_n = 1'b0;
    wclk(6);
    chk("busy_in_shift", busy, 1'b1);
  endtask

  task automatic cs_stop();
    wclk(2);
    cs_n = 1'b1;
    wclk(8);
    chk("busy_after_cs_high", busy, 1'b0);
  endtask

  // Shift nbits of mo MSB-first at clk/8; miso is checked just before each
  // rising edge against the captured transmit word. A full word is pushed
  // to the scoreboard on its last rising edge.
  task automatic shift_word(input logic [W-1:0] mo, input int nbits,
                            input logic [W-1:0] tx_next, input bit cs_with_last);
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[W-1-i];
      wclk(4);
      chk("miso_bit", miso, TX_EN ? tx_cap[W-1-i] : 1'b0);
      if (i == W-1) tx_word = tx_next;
      sclk = 1'b1;
      if (i == W-1) begin
        if (cs_with_last) cs_n = 1'b1;
        exp_q.push_back(mo);
        tx_cap = tx_word;
      end
      wclk(4);
      sclk = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] last_w;
    logic [W-1:0] w;
    int           nw;

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_word = '0; tx_cap = '0;
    wclk(3);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_miso", miso, 0);
    rst = 1'b0;
    wclk(4);

    // single word
    cs_start();
    shift_word(8'hA5, W, 8'h00, 1'b0);
    cs_stop();
    chk("single_rx_data", rx_data, 8'hA5);

    // back-to-back words under one chip select
    tx_word = 8'h5E;
    cs_start();
    shift_word(8'h3C, W, 8'hB1, 1'b0);
    shift_word(8'hC3, W, 8'h00, 1'b0);
    cs_stop();
    chk("b2b_rx_data", rx_data, 8'hC3);

    // abort after 5 bits keeps the previous word
    cs_start();
    shift_word(8'h12, W, 8'h00, 1'b0);
    cs_stop();
    cs_start();
    shift_word(8'hFF, 5, 8'h00, 1'b0);
    cs_stop();
    chk("abort_rx_data", rx_data, 8'h12);

    // transmit pattern while receiving zero
    tx_word = 8'h81;
    cs_start();
    shift_word(8'h00, W, 8'h00, 1'b0);
    cs_stop();
    chk("tx_test_rx_data", rx_data, 8'h00);

    // cs_n rises together with the completing edge
    cs_start();
    shift_word(8'h69, W, 8'h00, 1'b1);
    wclk(8);
    chk("simul_busy", busy, 1'b0);
    chk("simul_rx_data", rx_data, 8'h69);

    // asynchronous reset mid-word
    tx_word = 8'hF0;
    cs_start();
    shift_word(8'hFF, 3, 8'h00, 1'b0);
    wclk(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rx_data", rx_data, 0);
    chk("async_rst_rx_valid", rx_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_miso", miso, 0);
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wclk(3);
    rst = 1'b0;
    wclk(3);
    tx_word = 8'h00;
    cs_start();
    shift_word(8'h5A, W, 8'h00, 1'b0);
    cs_stop();
    chk("post_rst_rx_data", rx_data, 8'h5A);
    last_w = 8'h5A;

    // randomized bursts with an occasional abort
    for (int g = 0; g < 6; g++) begin
      tx_word = W'($urandom);
      cs_start();
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        w = W'($urandom);
        shift_word(w, W, W'($urandom), 1'b0);
        last_w = w;
      end
      if ($urandom_range(0, 1) == 1) begin
        shift_word(W'($urandom), $urandom_range(1, W-1), 8'h00, 1'b0);
      end
      cs_stop();
      chk("random_rx_data", rx_data, last_w);
    end

    wclk(10);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
